pixel_unpacker: RTL
===================

PIXEL_UNPACKER -- requirements
Module: pixel_unpacker

Interface
REQ-001 Parameter IMG_W, default 640, pixels per line.
REQ-002 Parameter IMG_H, default 480, lines per frame.
REQ-003 Parameter BPP, default 1, bits per pixel; legal values 1, 2, 4, 8; PPB = 8/BPP pixels per byte.
REQ-004 Parameter LSB_FIRST, default 1; 1 = first pixel taken from data_in[BPP-1:0], 0 = first pixel from data_in[7:8-BPP].
REQ-005 Parameter XW, default 10, x_out width; YW, default 9, y_out width.
REQ-006 Port clock, in, 1, sole clock; all logic on rising edge.
REQ-007 Port reset, in, 1, synchronous, active-high.
REQ-008 Port start, in, 1, one-cycle pulse arming a new frame.
REQ-009 Port byte_valid, in, 1, data_in holds a received byte.
REQ-010 Port data_in, in, 8, packed pixel byte.
REQ-011 Port byte_ready, out, 1, block accepts a byte this cycle.
REQ-012 Port pix_valid, out, 1, pix_data/x_out/y_out valid this cycle.
REQ-013 Port pix_data, out, BPP, unpacked pixel value.
REQ-014 Port x_out, out, XW; y_out, out, YW; coordinates of the current pixel.
REQ-015 Port frame_done, out, 1, one-cycle pulse coincident with the last pixel of a frame.
REQ-016 Port overrun_err, out, 1, sticky: a byte was offered and dropped while running.

Function
REQ-017 States IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on last pixel; DONE->RUN on start; DONE never returns to IDLE except by reset.
REQ-018 start in any state clears x/y counters to 0, flushes shift register, enters RUN next cycle; start in RUN restarts the frame without error flag.
REQ-019 byte_ready = state RUN and start low and (remaining pixels in shift register <= 1); combinational.
REQ-020 Byte accepted on a rising edge with byte_valid and byte_ready high; latched into shift register.
REQ-021 Latency: first pixel of an accepted byte on pix_valid in the next cycle; remaining PPB-1 pixels on consecutive cycles, no gaps.
REQ-022 Back-to-back bytes: a byte accepted while the last pixel of the previous byte is output produces its first pixel the following cycle (continuous pix_valid stream).
REQ-023 byte_valid high with byte_ready low in RUN: byte dropped, overrun_err set; in IDLE/DONE: byte ignored, no flag.
REQ-024 x_out increments per output pixel; at IMG_W-1 wraps to 0 and y_out increments.
REQ-025 Pixel at (IMG_W-1, IMG_H-1): pix_valid and frame_done high same cycle; state DONE next cycle; leftover pixels in the byte discarded, no further pix_valid.
REQ-026 x_out/y_out/pix_data hold last values when pix_valid low.
REQ-027 overrun_err cleared only by reset or start.

Reset
REQ-028 On reset: state IDLE, byte_ready 0, pix_valid 0, pix_data 0, x_out 0, y_out 0, frame_done 0, overrun_err 0, shift register empty.
REQ-029 Reset has priority over start and byte_valid in the same cycle; reset mid-frame abandons the frame, no frame_done.

Verification
REQ-030 Defaults, start, then 38400 bytes each offered when byte_ready -> 307200 pix_valid pulses, first at (0,0), frame_done with (639,479), overrun_err 0.
REQ-031 IMG_W=4, IMG_H=2, BPP=2, LSB_FIRST=1, bytes 0xE4, 0x1B -> pix_data 0,1,2,3 at y=0 then 3,2,1,0 at y=1; frame_done on the 8th pixel; LSB_FIRST=0 -> 3,2,1,0 then 0,1,2,3.
REQ-032 BPP=1, byte_valid held high continuously -> byte_ready high one cycle in eight after the first accept, pix_valid continuous, no overrun_err.
REQ-033 BPP=1, second byte forced while 3 pixels remain -> byte dropped, overrun_err 1, pixel count unchanged; start clears it.
REQ-034 Reset asserted at pixel (100,5) -> next cycle all outputs 0, IDLE; bytes ignored until start.
REQ-035 IMG_W=3, IMG_H=1, BPP=2 (PPB=4) -> 3 pixels output, frame_done on 3rd, 4th pixel discarded, byte_ready 0 in DONE.

Source files
------------

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: splits packed pixel bytes into a raster-ordered pixel stream
// with x/y coordinates, a frame_done marker and a sticky overrun flag.
module pixel_unpacker #(
    parameter int unsigned IMG_W     = 640,
    parameter int unsigned IMG_H     = 480,
    parameter int unsigned BPP       = 1,
    parameter int unsigned LSB_FIRST = 1,
    parameter int unsigned XW        = 10,
    parameter int unsigned YW        = 9
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           byte_valid,
    input  logic [7:0]     data_in,
    output logic           byte_ready,
    output logic           pix_valid,
    output logic [BPP-1:0] pix_data,
    output logic [XW-1:0]  x_out,
    output logic [YW-1:0]  y_out,
    output logic           frame_done,
    output logic           overrun_err
);

    localparam int unsigned PPB = 8 / BPP;
    localparam int unsigned RW  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     sr_q, sr_d;
    logic [RW-1:0]  rem_q, rem_d;
    logic [XW-1:0]  x_cnt_q, x_cnt_d;
    logic [YW-1:0]  y_cnt_q, y_cnt_d;
    logic           pix_valid_q, pix_valid_d;
    logic [BPP-1:0] pix_data_q, pix_data_d;
    logic [XW-1:0]  x_out_q, x_out_d;
    logic [YW-1:0]  y_out_q, y_out_d;
    logic           frame_done_q, frame_done_d;
    logic           overrun_q, overrun_d;
    logic           bv_prev_q, bv_prev_d;

    logic           accept;
    logic           drop;
    logic           emit;
    logic [BPP-1:0] pix_sel;
    logic           x_last;
    logic           y_last;

    // Pixel that leaves a byte first, given the configured packing order.
    function automatic logic [BPP-1:0] first_pix(input logic [7:0] b);
        if (LSB_FIRST != 0) begin
            return b[BPP-1:0];
        end else begin
            return b[7:8-BPP];
        end
    endfunction

    // Byte with its first pixel consumed, so the next pixel sits in the same slot.
    function automatic logic [7:0] advance(input logic [7:0] b);
        if (LSB_FIRST != 0) begin
            return b >> BPP;
        end else begin
            return b << BPP;
        end
    endfunction

    // Ready once the pixel currently on the output is the last one held.
    assign byte_ready = (state_q == RUN) && !start && (rem_q == '0);
    assign accept     = byte_valid && byte_ready;

    // A byte_valid held high while not ready is a waiting source; only a newly
    // raised byte_valid that cannot be taken counts as a dropped byte.
    assign drop       = byte_valid && !byte_ready && !bv_prev_q;

    assign x_last     = (x_cnt_q == XW'(IMG_W - 1));
    assign y_last     = (y_cnt_q == YW'(IMG_H - 1));

    // Next-state, shift register, raster counters and output pixel.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        rem_d        = rem_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        pix_valid_d  = 1'b0;
        pix_data_d   = pix_data_q;
        x_out_d      = x_out_q;
        y_out_d      = y_out_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        bv_prev_d    = byte_valid;
        emit         = 1'b0;
        pix_sel      = '0;

        if (start) begin
            state_d   = RUN;
            sr_d      = '0;
            rem_d     = '0;
            x_cnt_d   = '0;
            y_cnt_d   = '0;
            overrun_d = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (drop) begin
                        overrun_d = 1'b1;
                    end

                    if (accept) begin
                        emit    = 1'b1;
                        pix_sel = first_pix(data_in);
                        sr_d    = advance(data_in);
                        rem_d   = RW'(PPB - 1);
                    end else if (rem_q != '0) begin
                        emit    = 1'b1;
                        pix_sel = first_pix(sr_q);
                        sr_d    = advance(sr_q);
                        rem_d   = rem_q - RW'(1);
                    end

                    if (emit) begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = pix_sel;
                        x_out_d     = x_cnt_q;
                        y_out_d     = y_cnt_q;
                        if (x_last) begin
                            x_cnt_d = '0;
                            if (y_last) begin
                                // Last pixel of the frame: leftovers in the byte are discarded.
                                y_cnt_d      = '0;
                                frame_done_d = 1'b1;
                                state_d      = DONE;
                                rem_d        = '0;
                                sr_d         = '0;
                            end else begin
                                y_cnt_d = y_cnt_q + YW'(1);
                            end
                        end else begin
                            x_cnt_d = x_cnt_q + XW'(1);
                        end
                    end
                end
                IDLE: begin
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            rem_q        <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            bv_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            rem_q        <= rem_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            bv_prev_q    <= bv_prev_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign x_out       = x_out_q;
    assign y_out       = y_out_q;
    assign frame_done  = frame_done_q;
    assign overrun_err = overrun_q;

endmodule
